mux2to1_sweep_tester: RTL and testbench



---
 rtl/mux_tester_pkg.sv | 22 ++
 rtl/mux2to1_sweep_tester_sync2ff.sv | 23 ++
 rtl/mux2to1_sweep_tester.sv | 136 +++++++++++++
 tb/tb_mux2to1_sweep_tester.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_tester_pkg.sv
// Shared types and constants for the 2:1 mux sweep tester.
package mux_tester_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StApply,
      StSettle,
      StCheck,
      StDone
   } state_t;

   localparam int unsigned NUM_VECTORS  = 8;
   localparam int unsigned IDX_W        = 3;
   localparam int unsigned FAIL_CNT_W   = 4;
   localparam int unsigned FAIL_CNT_MAX = 15;

   // Reference 2:1 mux: idx[2] selects, idx[1] is the select-1 data, idx[0] select-0 data.
   function automatic logic expected_m(input logic [IDX_W-1:0] idx);
      return idx[2] ? idx[1] : idx[0];
   endfunction

endpackage

// File: rtl/mux2to1_sweep_tester_sync2ff.sv
// Two-flop synchronizer for the asynchronous m input of the mux under test.
// Only instantiated when MUX_TESTER_SYNC_IN_EN is defined.
module sync2ff (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   // Two-stage shift; first stage may go metastable, second resolves it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/mux2to1_sweep_tester.sv
// Sweep stimulus/checker for a lab 2:1 multiplexer.
// Drives all 8 (x, y, s) combinations, waits a settle interval per vector, compares m against
// s ? y : x and reports pass/fail, a per-vector failure bitmap and the first failing index.
// Optional: define MUX_TESTER_SYNC_IN_EN to pass m_in through a two-flop synchronizer; SETTLE
// is then stretched by two cycles to cover the synchronizer delay.
module mux2to1_sweep_tester
   import mux_tester_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned NUM_PASSES    = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  m_in,
   output logic                  x_out,
   output logic                  y_out,
   output logic                  s_out,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [FAIL_CNT_W-1:0] fail_count,
   output logic [7:0]            fail_vector,
   output logic [IDX_W-1:0]      first_fail_idx
);

   localparam int unsigned SETTLE_W = 9;
   localparam int unsigned PASS_W   = 4;

`ifdef MUX_TESTER_SYNC_IN_EN
   localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES + 2);
`else
   localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES);
`endif

   localparam logic [PASS_W-1:0]     LAST_PASS = PASS_W'(NUM_PASSES - 1);
   localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_VECTORS - 1);
   localparam logic [FAIL_CNT_W-1:0] CNT_MAX   = FAIL_CNT_W'(FAIL_CNT_MAX);

   state_t              state;
   logic [IDX_W-1:0]    idx;
   logic [PASS_W-1:0]   pass_cnt;
   logic [SETTLE_W-1:0] settle_cnt;
   logic                m_sample;
   logic                mismatch;
   logic                last_vector;

`ifdef MUX_TESTER_SYNC_IN_EN
   sync2ff u_sync (
      .clock (clock),
      .reset (reset),
      .d     (m_in),
      .q     (m_sample)
   );
`else
   assign m_sample = m_in;
`endif

   assign mismatch    = (m_sample != expected_m(idx));
   assign last_vector = (idx == LAST_IDX) && (pass_cnt == LAST_PASS);

   // Sweep FSM; every output is a register updated alongside the state transition.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= StIdle;
         idx            <= '0;
         pass_cnt       <= '0;
         settle_cnt     <= '0;
         x_out          <= 1'b0;
         y_out          <= 1'b0;
         s_out          <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         fail_count     <= '0;
         fail_vector    <= '0;
         first_fail_idx <= '0;
      end else begin
         unique case (state)
            StIdle, StDone: begin
               if (start) begin
                  state          <= StApply;
                  idx            <= '0;
                  pass_cnt       <= '0;
                  {s_out, y_out, x_out} <= '0;
                  busy           <= 1'b1;
                  done           <= 1'b0;
                  pass           <= 1'b0;
                  fail_count     <= '0;
                  fail_vector    <= '0;
                  first_fail_idx <= '0;
               end
            end
            StApply: begin
               settle_cnt <= SETTLE_LOAD;
               state      <= StSettle;
            end
            StSettle: begin
               settle_cnt <= settle_cnt - SETTLE_W'(1);
               if (settle_cnt == SETTLE_W'(1)) begin
                  state <= StCheck;
               end
            end
            StCheck: begin
               if (mismatch) begin
                  fail_vector[idx] <= 1'b1;
                  if (fail_count != CNT_MAX) begin
                     fail_count <= fail_count + FAIL_CNT_W'(1);
                  end
                  // fail_count never returns to zero once bumped, so zero marks the first miss
                  if (fail_count == '0) begin
                     first_fail_idx <= idx;
                  end
               end
               if (last_vector) begin
                  state <= StDone;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (fail_count == '0) && !mismatch;
               end else begin
                  state <= StApply;
                  idx   <= idx + IDX_W'(1);
                  {s_out, y_out, x_out} <= idx + IDX_W'(1);
                  if (idx == LAST_IDX) begin
                     pass_cnt <= pass_cnt + PASS_W'(1);
                  end
               end
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux2to1_sweep_tester.sv
// Bench for mux2to1_sweep_tester: behavioural mux models feed m_in, run results are predicted
// into a queue at start and compared when done rises.
module tb_mux2to1_sweep_tester;

   localparam int SETTLE = 2;
`ifdef MUX_TESTER_SYNC_IN_EN
   localparam int PER_VEC = 4 + SETTLE;
`else
   localparam int PER_VEC = 2 + SETTLE;
`endif
   localparam int LIMIT = 1000;

   // Mux models: 0 ideal, 1 stuck-at-0, 2 swapped data, 3 stuck-at-1
   localparam int M_IDEAL = 0;
   localparam int M_SA0   = 1;
   localparam int M_SWAP  = 2;
   localparam int M_SA1   = 3;

   logic       clock = 1'b0;
   logic       reset;
   logic       start, start3;
   logic       m_in, m_in3;
   logic       x_out, y_out, s_out, busy, done, pass;
   logic [3:0] fail_count;
   logic [7:0] fail_vector;
   logic [2:0] first_fail_idx;
   logic       x3, y3, s3, busy3, done3, pass3;
   logic [3:0] fail_count3;
   logic [7:0] fail_vector3;
   logic [2:0] first_fail_idx3;
   int         mode  = M_IDEAL;
   int         mode3 = M_IDEAL;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   typedef struct {
      string      tag;
      int         lat;
      logic       pass;
      logic [3:0] fc;
      logic [7:0] fv;
      logic [2:0] ffi;
   } exp_t;

   exp_t sb[$];

   always #5 clock = ~clock;

   function automatic logic mux_model(input int md, input logic x, input logic y, input logic s);
      case (md)
         M_SA0:   return 1'b0;
         M_SWAP:  return s ? x : y;
         M_SA1:   return 1'b1;
         default: return s ? y : x;
      endcase
   endfunction

   always_comb m_in  = mux_model(mode, x_out, y_out, s_out);
   always_comb m_in3 = mux_model(mode3, x3, y3, s3);

   mux2to1_sweep_tester #(.SETTLE_CYCLES(SETTLE), .NUM_PASSES(1)) dut (
      .clock          (clock),
      .reset          (reset),
      .start          (start),
      .m_in           (m_in),
      .x_out          (x_out),
      .y_out          (y_out),
      .s_out          (s_out),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .fail_count     (fail_count),
      .fail_vector    (fail_vector),
      .first_fail_idx (first_fail_idx)
   );

   mux2to1_sweep_tester #(.SETTLE_CYCLES(SETTLE), .NUM_PASSES(3)) dut3 (
      .clock          (clock),
      .reset          (reset),
      .start          (start3),
      .m_in           (m_in3),
      .x_out          (x3),
      .y_out          (y3),
      .s_out          (s3),
      .busy           (busy3),
      .done           (done3),
      .pass           (pass3),
      .fail_count     (fail_count3),
      .fail_vector    (fail_vector3),
      .first_fail_idx (first_fail_idx3)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Independent prediction of a whole run from the mux model and the ideal s ? y : x.
   function automatic exp_t predict(input string tag, input int md, input int passes);
      exp_t e;
      logic x, y, s, ideal;
      bit   seen;
      e.tag = tag;
      e.fc  = '0;
      e.fv  = '0;
      e.ffi = '0;
      seen  = 1'b0;
      for (int p = 0; p < passes; p++) begin
         for (int i = 0; i < 8; i++) begin
            x     = i[0];
            y     = i[1];
            s     = i[2];
            ideal = s ? y : x;
            if (mux_model(md, x, y, s) !== ideal) begin
               e.fv[i] = 1'b1;
               if (e.fc != 4'd15) e.fc = e.fc + 4'd1;
               if (!seen) e.ffi = i[2:0];
               seen = 1'b1;
            end
         end
      end
      e.pass = (e.fc == 4'd0);
      e.lat  = passes * 8 * PER_VEC;
      return e;
   endfunction

   task automatic pulse_start(input bit use3);
      @(posedge clock);
      #1;
      if (use3) start3 = 1'b1; else start = 1'b1;
      @(posedge clock);
      #1;
      start  = 1'b0;
      start3 = 1'b0;
   endtask

   task automatic start_run(input bit use3, input string tag, input int md, input int passes);
      if (use3) mode3 = md; else mode = md;
      sb.push_back(predict(tag, md, passes));
      pulse_start(use3);
      check({tag, ".busy_rise"}, use3 ? busy3 : busy, 1'b1);
      check({tag, ".done_fall"}, use3 ? done3 : done, 1'b0);
      check({tag, ".fv_clear"}, use3 ? fail_vector3 : fail_vector, 8'h00);
      check({tag, ".fc_clear"}, use3 ? fail_count3 : fail_count, 4'd0);
   endtask

   // Counts cycles from the start-sampling edge until done; start is released after `hold` cycles.
   task automatic wait_and_score(input bit use3, input int hold);
      exp_t e;
      int   cyc;
      cyc = 0;
      while (!(use3 ? done3 : done) && cyc < LIMIT) begin
         if (cyc >= hold) begin
            start  = 1'b0;
            start3 = 1'b0;
         end
         @(posedge clock);
         #1;
         cyc++;
      end
      start  = 1'b0;
      start3 = 1'b0;
      e = sb.pop_front();
      check({e.tag, ".latency"}, cyc, e.lat);
      check({e.tag, ".busy"}, use3 ? busy3 : busy, 1'b0);
      check({e.tag, ".pass"}, use3 ? pass3 : pass, e.pass);
      check({e.tag, ".fail_count"}, use3 ? fail_count3 : fail_count, e.fc);
      check({e.tag, ".fail_vector"}, use3 ? fail_vector3 : fail_vector, e.fv);
      check({e.tag, ".first_fail_idx"}, use3 ? first_fail_idx3 : first_fail_idx, e.ffi);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".busy"}, busy, 1'b0);
      check({tag, ".done"}, done, 1'b0);
      check({tag, ".pass"}, pass, 1'b0);
      check({tag, ".fail_count"}, fail_count, 4'd0);
      check({tag, ".fail_vector"}, fail_vector, 8'h00);
      check({tag, ".first_fail_idx"}, first_fail_idx, 3'd0);
      check({tag, ".xys"}, {s_out, y_out, x_out}, 3'b000);
   endtask

   initial begin
      reset  = 1'b1;
      start  = 1'b0;
      start3 = 1'b0;
      #1;
      check_all_zero("reset");
      @(posedge clock);
      #2;
      reset = 1'b0;

      // Ideal mux, default build
      start_run(1'b0, "ideal", M_IDEAL, 1);
      wait_and_score(1'b0, 0);
      check("ideal.done", done, 1'b1);

      // Stuck-at-0 output, then swapped data inputs (each start lands in DONE)
      start_run(1'b0, "sa0", M_SA0, 1);
      wait_and_score(1'b0, 0);
      start_run(1'b0, "swap", M_SWAP, 1);
      wait_and_score(1'b0, 0);

      // Asynchronous reset mid-sweep clears everything before the next edge
      mode = M_IDEAL;
      pulse_start(1'b0);
      repeat (9) @(posedge clock);
      #1;
      check("midrst.busy_before", busy, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      check_all_zero("midrst");
      start = 1'b1;
      @(posedge clock);
      #1;
      check("rst_wins.busy", busy, 1'b0);
      start = 1'b0;
      #1;
      reset = 1'b0;
      start_run(1'b0, "after_rst", M_IDEAL, 1);
      wait_and_score(1'b0, 0);

      // start held high while busy: exactly one run, then DONE holds
      mode = M_IDEAL;
      sb.push_back(predict("held", M_IDEAL, 1));
      @(posedge clock);
      #1;
      start = 1'b1;
      @(posedge clock);
      #1;
      wait_and_score(1'b0, 8 * PER_VEC - 1);
      repeat (3) @(posedge clock);
      #1;
      check("held.done_stays", done, 1'b1);
      check("held.busy_stays_low", busy, 1'b0);

      // A fresh start from DONE reports independently of the previous run
      start_run(1'b0, "rerun_sa1", M_SA1, 1);
      wait_and_score(1'b0, 0);

      // Three-pass instance with m stuck at 1
      start_run(1'b1, "np3_sa1", M_SA1, 3);
      wait_and_score(1'b1, 0);
      check("np3.done", done3, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
